coeff_load_sequencer: RTL and testbench

//  Initiator side of the FIR coefficient-RAM command interface. Accepts taps over a

---
 rtl/coeff_load_sequencer.sv | 172 +++++++++++++++++
 tb/tb_coeff_load_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_load_sequencer.sv
// Coefficient-RAM command sequencer for the FIR controller: write burst, release, read sweeps, handoff.
// Optional build macro COEFF_CHECKSUM_EN adds oChecksum, the 16-bit wrapping sum of the accepted taps.
module coeff_load_sequencer #(
    parameter int P_NUM_TAP = 33,
    parameter int P_ADDR_W  = 6,
    parameter int P_DATA_W  = 16
) (
    input  logic                       iClk_12M,
    input  logic                       iRsn,
    input  logic                       iUpdateReq,
    input  logic                       iCoeffValid,
    input  logic signed [P_DATA_W-1:0] iCoeffData,
    output logic                       oCoeffReady,
    input  logic                       iSampleEn,
    output logic                       oCoeffiUpdateFlag,
    output logic                       oCsnRam,
    output logic                       oWrnRam,
    output logic [P_ADDR_W-1:0]        oAddrRam,
    output logic signed [P_DATA_W-1:0] oWrDtRam,
    output logic                       oLoadDone,
`ifdef COEFF_CHECKSUM_EN
    output logic [15:0]                oChecksum,
`endif
    output logic                       oOverrun
);

    localparam int CNT_W = $clog2(P_NUM_TAP + 1);
    localparam logic [CNT_W-1:0]    NUM_TAP   = CNT_W'(P_NUM_TAP);
    localparam logic [P_ADDR_W-1:0] LAST_ADDR = P_ADDR_W'(P_NUM_TAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WRITE, ST_RELEASE, ST_RUN, ST_SWEEP, ST_HANDOFF
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wrCnt;
    logic             armHold;
    logic             relCnt;
    logic             updPend;
    logic             accept;

`ifdef COEFF_CHECKSUM_EN
    function automatic logic [15:0] csumAdd(input logic [15:0] acc,
                                            input logic signed [P_DATA_W-1:0] d);
        logic signed [15:0] ext;
        ext = 16'(d);
        return acc + ext;
    endfunction
`endif

    assign accept = iCoeffValid && oCoeffReady;

    always_ff @(posedge iClk_12M) begin
        if (!iRsn) begin
            state             <= ST_IDLE;
            wrCnt             <= '0;
            armHold           <= 1'b0;
            relCnt            <= 1'b0;
            updPend           <= 1'b0;
            oCoeffReady       <= 1'b0;
            oCoeffiUpdateFlag <= 1'b0;
            oCsnRam           <= 1'b1;
            oWrnRam           <= 1'b1;
            oAddrRam          <= '0;
            oWrDtRam          <= '0;
            oLoadDone         <= 1'b0;
            oOverrun          <= 1'b0;
`ifdef COEFF_CHECKSUM_EN
            oChecksum         <= '0;
`endif
        end else begin
            oLoadDone <= 1'b0;
            oOverrun  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iUpdateReq) begin
                        state       <= ST_WRITE;
                        wrCnt       <= '0;
                        armHold     <= 1'b0;
                        oCoeffReady <= 1'b1;
`ifdef COEFF_CHECKSUM_EN
                        oChecksum   <= '0;
`endif
                    end
                end
                ST_WRITE: begin
                    oOverrun <= iSampleEn;
                    if (accept) begin
                        oCoeffiUpdateFlag <= 1'b1;
                        oCsnRam           <= 1'b0;
                        oWrnRam           <= 1'b0;
                        oAddrRam          <= P_ADDR_W'(wrCnt);
                        oWrDtRam          <= iCoeffData;
                        wrCnt             <= wrCnt + CNT_W'(1);
                        // The first beat also arms the controller, so it stays on the bus one extra cycle.
                        armHold           <= (wrCnt == '0);
                        oCoeffReady       <= (wrCnt != '0) && (int'(wrCnt) + 1 < P_NUM_TAP);
`ifdef COEFF_CHECKSUM_EN
                        oChecksum         <= csumAdd(oChecksum, iCoeffData);
`endif
                    end else begin
                        armHold     <= 1'b0;
                        oCoeffReady <= (wrCnt < NUM_TAP);
                        if (wrCnt == NUM_TAP && !armHold) begin
                            state             <= ST_RELEASE;
                            relCnt            <= 1'b0;
                            oCoeffiUpdateFlag <= 1'b0;
                            oCsnRam           <= 1'b1;
                            oWrnRam           <= 1'b1;
                            oAddrRam          <= '0;
                            oWrDtRam          <= '0;
                        end
                    end
                end
                ST_RELEASE: begin
                    oOverrun <= iSampleEn;
                    relCnt   <= 1'b1;
                    if (relCnt) begin
                        state     <= ST_RUN;
                        oLoadDone <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (iSampleEn) begin
                        state    <= ST_SWEEP;
                        oCsnRam  <= 1'b0;
                        oAddrRam <= '0;
                        oWrDtRam <= '0;
                        updPend  <= updPend || iUpdateReq;
                    end else if (iUpdateReq || updPend) begin
                        state             <= ST_HANDOFF;
                        oCoeffiUpdateFlag <= 1'b1;
                        oWrnRam           <= 1'b0;
                        updPend           <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    oOverrun <= iSampleEn;
                    if (oAddrRam == LAST_ADDR) begin
                        oCsnRam  <= 1'b1;
                        oAddrRam <= '0;
                        if (updPend || iUpdateReq) begin
                            state             <= ST_HANDOFF;
                            oCoeffiUpdateFlag <= 1'b1;
                            oWrnRam           <= 1'b0;
                            updPend           <= 1'b0;
                        end else begin
                            state <= ST_RUN;
                        end
                    end else begin
                        oAddrRam <= oAddrRam + P_ADDR_W'(1);
                        updPend  <= updPend || iUpdateReq;
                    end
                end
                ST_HANDOFF: begin
                    oOverrun          <= iSampleEn;
                    state             <= ST_WRITE;
                    wrCnt             <= '0;
                    armHold           <= 1'b0;
                    oCoeffReady       <= 1'b1;
                    oCoeffiUpdateFlag <= 1'b0;
                    oWrnRam           <= 1'b1;
`ifdef COEFF_CHECKSUM_EN
                    oChecksum         <= '0;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coeff_load_sequencer.sv
// Directed bench for coeff_load_sequencer: load, gapped load, sweeps, overrun, handoff, mid-load reset.
module tb_coeff_load_sequencer;

    logic        clk12M = 1'b0;
    logic        rsn;
    logic        updReq;
    logic        coeffValid;
    logic [15:0] coeffData;
    logic        coeffReady;
    logic        sampleEn;
    logic        updFlag;
    logic        csnRam;
    logic        wrnRam;
    logic [5:0]  addrRam;
    logic [15:0] wrDtRam;
    logic        loadDone;
    logic        overrun;
`ifdef COEFF_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int nAssert = 0;
    int nFail   = 0;

    coeff_load_sequencer dut (
        .iClk_12M          (clk12M),
        .iRsn              (rsn),
        .iUpdateReq        (updReq),
        .iCoeffValid       (coeffValid),
        .iCoeffData        (coeffData),
        .oCoeffReady       (coeffReady),
        .iSampleEn         (sampleEn),
        .oCoeffiUpdateFlag (updFlag),
        .oCsnRam           (csnRam),
        .oWrnRam           (wrnRam),
        .oAddrRam          (addrRam),
        .oWrDtRam          (wrDtRam),
        .oLoadDone         (loadDone),
`ifdef COEFF_CHECKSUM_EN
        .oChecksum         (checksum),
`endif
        .oOverrun          (overrun)
    );

    always #5 clk12M = ~clk12M;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(negedge clk12M);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus snapshot packed as {flag, csn, wrn, addr, data}.
    function automatic logic [31:0] busv(input logic f, input logic c, input logic w,
                                         input logic [5:0] a, input logic [15:0] d);
        return {7'd0, f, c, w, a, d};
    endfunction

    function automatic logic [31:0] busObs();
        return {7'd0, updFlag, csnRam, wrnRam, addrRam, wrDtRam};
    endfunction

    // Back-to-back beats starting from a cycle where Ready=1; data = base + k*step.
    task automatic burst(input string tag, input logic [15:0] base, input int step, input int nBeats);
        logic [15:0] d;
        coeffValid = 1'b1;
        coeffData  = base;
        tick;
        chk({tag, "_arm"}, busObs(), busv(1, 0, 0, 6'd0, base));
        chk({tag, "_armRdy"}, 32'(coeffReady), 32'd0);
        tick;
        chk({tag, "_wr0"}, busObs(), busv(1, 0, 0, 6'd0, base));
        chk({tag, "_wr0Rdy"}, 32'(coeffReady), 32'd1);
        for (int k = 1; k < nBeats; k++) begin
            d = base + 16'(k * step);
            coeffData = d;
            tick;
            chk({tag, "_beat"}, busObs(), busv(1, 0, 0, 6'(k), d));
            chk({tag, "_beatRdy"}, 32'(coeffReady), 32'(k < 32));
        end
    endtask

    // Extra Valid after the last beat, two release cycles, then a single oLoadDone.
    task automatic releaseSeq(input string tag);
        coeffValid = 1'b1;
        coeffData  = 16'h1234;
        tick;
        chk({tag, "_rel1"}, busObs(), busv(0, 1, 1, 6'd0, 16'd0));
        chk({tag, "_rel1Rdy"}, 32'(coeffReady), 32'd0);
        chk({tag, "_rel1Done"}, 32'(loadDone), 32'd0);
        coeffValid = 1'b0;
        tick;
        chk({tag, "_rel2"}, busObs(), busv(0, 1, 1, 6'd0, 16'd0));
        chk({tag, "_rel2Done"}, 32'(loadDone), 32'd0);
        tick;
        chk({tag, "_done"}, 32'(loadDone), 32'd1);
        chk({tag, "_runBus"}, busObs(), busv(0, 1, 1, 6'd0, 16'd0));
    endtask

    initial begin
        rsn = 1'b0; updReq = 1'b0; coeffValid = 1'b0; coeffData = '0; sampleEn = 1'b0;
        tick;
        tick;
        chk("rst_bus", busObs(), busv(0, 1, 1, 6'd0, 16'd0));
        chk("rst_rdy", 32'(coeffReady), 32'd0);
        chk("rst_done", 32'(loadDone), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        rsn = 1'b1;
        tick;

        // Test 1: back-to-back load of k*3
        updReq = 1'b1;
        tick;
        updReq = 1'b0;
        chk("t1_entryRdy", 32'(coeffReady), 32'd1);
        chk("t1_entryBus", busObs(), busv(0, 1, 1, 6'd0, 16'd0));
        burst("t1", 16'd0, 3, 33);
        releaseSeq("t1");
`ifdef COEFF_CHECKSUM_EN
        chk("t1_csum", 32'(checksum), 32'h0630);
`endif
        tick;
        chk("t1_doneOnce", 32'(loadDone), 32'd0);

        // Test 3: read sweep with an overrun at sweep cycle 10
        sampleEn = 1'b1;
        tick;
        sampleEn = 1'b0;
        for (int i = 0; i < 33; i++) begin
            chk("t3_sweep", busObs(), busv(0, 0, 1, 6'(i), 16'd0));
            chk("t3_ovr", 32'(overrun), 32'(i == 11));
            sampleEn = (i == 10);
            tick;
            sampleEn = 1'b0;
        end
        chk("t3_end", busObs(), busv(0, 1, 1, 6'd0, 16'd0));
        chk("t3_endOvr", 32'(overrun), 32'd0);

        // Test 4: update request mid-sweep goes pending, then handoff
        sampleEn = 1'b1;
        tick;
        sampleEn = 1'b0;
        for (int i = 0; i < 33; i++) begin
            chk("t4_sweep", busObs(), busv(0, 0, 1, 6'(i), 16'd0));
            updReq = (i == 5);
            tick;
            updReq = 1'b0;
        end
        chk("t4_handoff", busObs(), busv(1, 1, 0, 6'd0, 16'd0));
        chk("t4_handoffRdy", 32'(coeffReady), 32'd0);
        tick;
        chk("t4_write", busObs(), busv(0, 1, 1, 6'd0, 16'd0));
        chk("t4_writeRdy", 32'(coeffReady), 32'd1);

        // Test 2: 3-cycle Valid gaps, one overrun during WRITE
        tick;
        chk("t2_stall", busObs(), busv(0, 1, 1, 6'd0, 16'd0));
        for (int k = 0; k < 33; k++) begin
            coeffValid = 1'b1;
            coeffData  = 16'(k * 3);
            tick;
            coeffValid = 1'b0;
            chk("t2_beat", busObs(), busv(1, 0, 0, 6'(k), 16'(k * 3)));
            if (k == 0) chk("t2_armRdy", 32'(coeffReady), 32'd0);
            if (k == 32) chk("t2_lastRdy", 32'(coeffReady), 32'd0);
            if (k < 32) begin
                for (int j = 0; j < 3; j++) begin
                    sampleEn = (k == 5 && j == 0);
                    tick;
                    sampleEn = 1'b0;
                    chk("t2_hold", busObs(), busv(1, 0, 0, 6'(k), 16'(k * 3)));
                    chk("t2_ovr", 32'(overrun), 32'(k == 5 && j == 0));
                end
                chk("t2_gapRdy", 32'(coeffReady), 32'd1);
            end
        end
        releaseSeq("t2");

        // Test 5: reset at beat 17, then a fresh load of 7FFF taps
        updReq = 1'b1;
        tick;
        updReq = 1'b0;
        chk("t5_handoff", busObs(), busv(1, 1, 0, 6'd0, 16'd0));
        tick;
        chk("t5_writeRdy", 32'(coeffReady), 32'd1);
        burst("t5a", 16'h7FFF, 0, 18);
        rsn      = 1'b0;
        sampleEn = 1'b1;
        tick;
        coeffValid = 1'b0;
        chk("t5_rstBus", busObs(), busv(0, 1, 1, 6'd0, 16'd0));
        chk("t5_rstRdy", 32'(coeffReady), 32'd0);
        chk("t5_rstOvr", 32'(overrun), 32'd0);
        chk("t5_rstDone", 32'(loadDone), 32'd0);
        rsn = 1'b1;
        tick;
        chk("t5_idleOvr", 32'(overrun), 32'd0);
        chk("t5_idleRdy", 32'(coeffReady), 32'd0);
        sampleEn = 1'b0;
        updReq   = 1'b1;
        tick;
        updReq = 1'b0;
        chk("t5_idleOvr2", 32'(overrun), 32'd0);
        chk("t5_entryRdy", 32'(coeffReady), 32'd1);
        burst("t5b", 16'h7FFF, 0, 33);
        releaseSeq("t5b");
`ifdef COEFF_CHECKSUM_EN
        chk("t6_csum", 32'(checksum), 32'h7FDF);
`endif
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
